// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter that lets NUM_REQ local requesters share
// one APB completer port, sequencing IDLE -> SETUP -> ACCESS for each transfer
// and returning read data plus an OK/ERR response (ERR = pslverr or timeout).
module apb_rr_master #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PROTOCOL = 4,
  parameter int TIMEOUT  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]        req_prot,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [ADDR_W-1:0]           paddr,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [DATA_W-1:0]           pwdata,
  output logic [DATA_W/8-1:0]         pstrb,
  output logic [2:0]                  pprot,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int GW     = $clog2(NUM_REQ);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                gnt_found;
  logic [GW-1:0]       gnt_idx;
  logic [GW-1:0]       cand;

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept pulse is combinational so the requester sees it in the accept cycle
  // and can release req_valid on the following edge.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state and next-output computation for the APB phase sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    paddr_d      = paddr_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          paddr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwrite_d = req_write[gnt_idx];
          pwdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          // APB3 has no strobes/protection, and strobes are meaningless on reads.
          if (PROTOCOL == 3 || !req_write[gnt_idx]) begin
            pstrb_d = '0;
          end else begin
            pstrb_d = req_strb[int'(gnt_idx)*STRB_W +: STRB_W];
          end
          if (PROTOCOL == 3) begin
            pprot_d = '0;
          end else begin
            pprot_d = req_prot[int'(gnt_idx)*3 +: 3];
          end
          last_grant_d = gnt_idx;
          psel_d       = 1'b1;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (TIMEOUT > 0 && wait_cnt_q == TMO) begin
          // Abort: report ERR with zero data; any later pready lands in IDLE and is ignored.
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and points
  // last_grant at the top requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      paddr_q      <= paddr_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: an APB4 instance with TIMEOUT=4 and an
// APB3 instance with no timeout share the same stimulus.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_strb = '0;
  logic [N*3-1:0]  req_prot = '0;
  logic [DW-1:0]   prdata = '0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;

  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, pwdata;
  logic            rsp_err, psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;

  logic [N-1:0]    req_ready_3, rsp_valid_3;
  logic [DW-1:0]   rsp_rdata_3, pwdata_3;
  logic            rsp_err_3, psel_3, penable_3, pwrite_3;
  logic [AW-1:0]   paddr_3;
  logic [SW-1:0]   pstrb_3;
  logic [2:0]      pprot_3;

  int n_chk = 0;
  int n_err = 0;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PROTOCOL(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PROTOCOL(3), .TIMEOUT(0)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_3),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot), .rsp_valid(rsp_valid_3),
    .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3), .paddr(paddr_3), .psel(psel_3),
    .penable(penable_3), .pwrite(pwrite_3), .pwdata(pwdata_3), .pstrb(pstrb_3),
    .pprot(pprot_3), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_eq({pfx, " req_ready"}, req_ready, 0);
    chk_eq({pfx, " rsp_valid"}, rsp_valid, 0);
    chk_eq({pfx, " rsp_rdata"}, rsp_rdata, 0);
    chk_eq({pfx, " rsp_err"}, rsp_err, 0);
    chk_eq({pfx, " paddr"}, paddr, 0);
    chk_eq({pfx, " psel"}, psel, 0);
    chk_eq({pfx, " penable"}, penable, 0);
    chk_eq({pfx, " pwrite"}, pwrite, 0);
    chk_eq({pfx, " pwdata"}, pwdata, 0);
    chk_eq({pfx, " pstrb"}, pstrb, 0);
    chk_eq({pfx, " pprot"}, pprot, 0);
  endtask

  initial begin
    logic [N-1:0] pending;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;

    // Reset, with requests already pending: nothing may be accepted
    rst = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    req_valid = '0;
    tick();

    // Single read, requester 2, zero wait
    req_addr[2*AW +: AW] = 32'h40;
    req_write[2] = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk_eq("rd ready T", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk_eq("rd psel T+1", psel, 1);
    chk_eq("rd penable T+1", penable, 0);
    chk_eq("rd paddr", paddr, 32'h40);
    chk_eq("rd pwrite", pwrite, 0);
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    tick();
    chk_eq("rd penable T+2", penable, 1);
    chk_eq("rd rsp_valid T+2", rsp_valid, 0);
    tick();
    chk_eq("rd rsp_valid T+3", rsp_valid, 4'b0100);
    chk_eq("rd rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk_eq("rd rsp_err", rsp_err, 0);
    chk_eq("rd psel T+3", psel, 0);
    pready = 1'b0;

    // Write, requester 0, two wait states
    req_write[0] = 1'b1;
    req_wdata[0 +: DW] = 32'h12345678;
    req_strb[0 +: SW] = 4'h3;
    req_prot[0 +: 3] = 3'b010;
    req_addr[0 +: AW] = 32'h100;
    req_valid = 4'b0001;
    #1;
    chk_eq("wr ready T", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk_eq("wr pwrite", pwrite, 1);
    chk_eq("wr pwdata T+1", pwdata, 32'h12345678);
    chk_eq("wr pstrb T+1", pstrb, 4'h3);
    chk_eq("wr pprot", pprot, 3'b010);
    tick();
    chk_eq("wr penable T+2", penable, 1);
    chk_eq("wr pstrb T+2", pstrb, 4'h3);
    tick();
    chk_eq("wr pwdata T+3", pwdata, 32'h12345678);
    chk_eq("wr rsp_valid T+3", rsp_valid, 0);
    tick();
    pready = 1'b1;
    chk_eq("wr penable T+4", penable, 1);
    chk_eq("wr pstrb T+4", pstrb, 4'h3);
    chk_eq("wr rsp_valid T+4", rsp_valid, 0);
    tick();
    chk_eq("wr rsp_valid T+5", rsp_valid, 4'b0001);
    chk_eq("wr rsp_rdata", rsp_rdata, 0);
    chk_eq("wr rsp_err", rsp_err, 0);
    pready = 1'b0;

    // Four simultaneous requesters after reset; requester 0 re-requests later
    req_write = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pready = 1'b1;
    pending = 4'hF;
    for (int k = 0; k < 16; k++) begin
      req_valid = pending;
      #1;
      case (k)
        0, 12:   exp_rdy = 4'b0001;
        3:       exp_rdy = 4'b0010;
        6:       exp_rdy = 4'b0100;
        9:       exp_rdy = 4'b1000;
        default: exp_rdy = 4'b0000;
      endcase
      case (k)
        3, 15:   exp_rsp = 4'b0001;
        6:       exp_rsp = 4'b0010;
        9:       exp_rsp = 4'b0100;
        12:      exp_rsp = 4'b1000;
        default: exp_rsp = 4'b0000;
      endcase
      chk_eq($sformatf("rr ready k=%0d", k), req_ready, exp_rdy);
      chk_eq($sformatf("rr rsp_valid k=%0d", k), rsp_valid, exp_rsp);
      pending = pending & ~exp_rdy;
      if (k == 4) pending[0] = 1'b1;
      tick();
    end
    req_valid = '0;
    pready = 1'b0;

    // Read with pslverr, requester 1
    req_addr[1*AW +: AW] = 32'h80;
    req_valid = 4'b0010;
    #1;
    chk_eq("err ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'hA5A50001;
    tick();
    tick();
    chk_eq("err rsp_valid", rsp_valid, 4'b0010);
    chk_eq("err rsp_err", rsp_err, 1);
    chk_eq("err rsp_rdata", rsp_rdata, 32'hA5A50001);
    pready = 1'b0;
    pslverr = 1'b0;

    // Write with full strobes/prot: APB4 passes them, APB3 forces zero
    req_write[2] = 1'b1;
    req_wdata[2*DW +: DW] = 32'hCAFEF00D;
    req_strb[2*SW +: SW] = 4'hF;
    req_prot[2*3 +: 3] = 3'b111;
    req_valid = 4'b0100;
    #1;
    chk_eq("p3 ready apb4", req_ready, 4'b0100);
    chk_eq("p3 ready apb3", req_ready_3, 4'b0100);
    tick();
    req_valid = '0;
    chk_eq("p4 pstrb", pstrb, 4'hF);
    chk_eq("p4 pprot", pprot, 3'b111);
    chk_eq("p3 psel", psel_3, 1);
    chk_eq("p3 pwrite", pwrite_3, 1);
    chk_eq("p3 pstrb", pstrb_3, 0);
    chk_eq("p3 pprot", pprot_3, 0);
    pready = 1'b1;
    tick();
    tick();
    chk_eq("p3 rsp_valid", rsp_valid_3, 4'b0100);
    chk_eq("p3 rsp_err", rsp_err_3, 0);
    pready = 1'b0;

    // Timeout: requester 3 read with pready held low
    req_write[3] = 1'b0;
    req_addr[3*AW +: AW] = 32'hC0;
    req_valid = 4'b1000;
    #1;
    chk_eq("to ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk_eq($sformatf("to rsp_valid T+%0d", k), rsp_valid, 0);
      chk_eq($sformatf("to psel T+%0d", k), psel, 1);
    end
    tick();
    chk_eq("to rsp_valid T+7", rsp_valid, 4'b1000);
    chk_eq("to rsp_err", rsp_err, 1);
    chk_eq("to rsp_rdata", rsp_rdata, 0);
    chk_eq("to psel T+7", psel, 0);
    chk_eq("to penable T+7", penable, 0);
    pready = 1'b1;
    prdata = 32'hFFFF0000;
    tick();
    chk_eq("late pready rsp_valid", rsp_valid, 0);
    chk_eq("late pready rsp_rdata", rsp_rdata, 0);
    chk_eq("late pready psel", psel, 0);
    pready = 1'b0;
    tick();

    // Reset in the middle of ACCESS
    req_addr[1*AW +: AW] = 32'h123;
    req_valid = 4'b0010;
    #1;
    chk_eq("mid ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk_eq("mid penable", penable, 1);
    rst = 1'b1;
    tick();
    chk_all_zero("mid reset");
    rst = 1'b0;
    tick();
    req_valid = 4'hF;
    #1;
    chk_eq("post reset rsp_valid", rsp_valid, 0);
    chk_eq("post reset ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    pready = 1'b1;
    tick();
    tick();
    chk_eq("post reset rsp", rsp_valid, 4'b0001);
    pready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
